// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage with wait-state, stall and redirect handling
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        PCSrc,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemReady,
   input  logic [31:0] IMemData,
   output logic [31:0] PCAddResult,
   output logic [31:0] IF_Instruction,
   output logic        IF_Valid
);
   typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;
   state_t      r_state;
   logic [31:0] r_pc, r_redir, r_buf_instr, r_buf_pc4;
   logic        w_redirect;
   logic [31:0] w_target, w_pc4;
   // Jump wins over a taken branch; the fetch address is the PC itself
   always_comb begin
      w_redirect = Jump | PCSrc;
      w_target   = Jump ? JumpTarget : BranchTarget;
      w_pc4      = r_pc + 32'd4;
      IMemReq    = r_state != HOLD;
      IMemAddr   = r_pc;
   end
   // Fetch sequencing: in-flight requests are never aborted, so redirects wait in DRAIN
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state        <= FETCH;
         r_pc           <= RESET_PC;
         r_redir        <= '0;
         r_buf_instr    <= '0;
         r_buf_pc4      <= '0;
         IF_Instruction <= NOP_WORD;
         IF_Valid       <= 1'b0;
         PCAddResult    <= '0;
      end else begin
         case (r_state)
            FETCH: begin
               if (w_redirect) begin
                  IF_Instruction <= NOP_WORD;
                  IF_Valid       <= 1'b0;
                  if (IMemReady) r_pc <= w_target;
                  else begin
                     r_redir <= w_target;
                     r_state <= DRAIN;
                  end
               end else if (IMemReady) begin
                  r_pc <= w_pc4;
                  if (Stall) begin
                     r_buf_instr <= IMemData;
                     r_buf_pc4   <= w_pc4;
                     r_state     <= HOLD;
                  end else begin
                     IF_Instruction <= IMemData;
                     IF_Valid       <= 1'b1;
                     PCAddResult    <= w_pc4;
                  end
               end else if (!Stall) begin
                  IF_Instruction <= NOP_WORD;
                  IF_Valid       <= 1'b0;
               end
            end
            DRAIN: begin
               if (w_redirect || !Stall) begin
                  IF_Instruction <= NOP_WORD;
                  IF_Valid       <= 1'b0;
               end
               if (IMemReady) begin
                  r_pc    <= w_redirect ? w_target : r_redir;
                  r_state <= FETCH;
               end else if (w_redirect) r_redir <= w_target;
            end
            HOLD: begin
               if (w_redirect) begin
                  IF_Instruction <= NOP_WORD;
                  IF_Valid       <= 1'b0;
                  r_pc           <= w_target;
                  r_state        <= FETCH;
               end else if (!Stall) begin
                  IF_Instruction <= r_buf_instr;
                  IF_Valid       <= 1'b1;
                  PCAddResult    <= r_buf_pc4;
                  r_state        <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch streaming, wait states, stalls, redirects and reset
module tb_instr_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic        Clk = 1'b0, Rst = 1'b1, Stall = 1'b0, PCSrc = 1'b0, Jump = 1'b0, IMemReady = 1'b1;
   logic [31:0] BranchTarget = '0, JumpTarget = '0;
   logic        IMemReq, IF_Valid;
   logic [31:0] IMemAddr, PCAddResult, IF_Instruction, IMemData;
   int          n_chk = 0, n_pass = 0;
   instr_fetch_unit #(.RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
      .IMemReady(IMemReady), .IMemData(IMemData), .PCAddResult(PCAddResult),
      .IF_Instruction(IF_Instruction), .IF_Valid(IF_Valid)
   );
   assign IMemData = IMemAddr;
   always #5 Clk = ~Clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask
   task automatic out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p4, input logic req, input logic [31:0] addr);
      check({tag, ".valid"}, 32'(IF_Valid), 32'(v));
      check({tag, ".instr"}, IF_Instruction, ins);
      check({tag, ".pc4"}, PCAddResult, p4);
      check({tag, ".req"}, 32'(IMemReq), 32'(req));
      check({tag, ".addr"}, IMemAddr, addr);
   endtask
   task automatic do_reset();
      Rst = 1'b1; Stall = 1'b0; PCSrc = 1'b0; Jump = 1'b0; IMemReady = 1'b1;
      tick();
      Rst = 1'b0;
   endtask
   initial begin
      tick();
      do_reset();
      out("reset", 0, NOP, 0, 1, 0);
      tick(); out("zw1", 1, 32'h0, 32'h4, 1, 32'h4);
      tick(); out("zw2", 1, 32'h4, 32'h8, 1, 32'h8);
      tick(); out("zw3", 1, 32'h8, 32'hC, 1, 32'hC);
      do_reset();
      tick(); tick();
      IMemReady = 1'b0;
      tick(); out("ws1", 0, NOP, 32'h8, 1, 32'h8);
      tick(); out("ws2", 0, NOP, 32'h8, 1, 32'h8);
      IMemReady = 1'b1;
      tick(); out("ws3", 1, 32'h8, 32'hC, 1, 32'hC);
      do_reset();
      tick(); out("st0", 1, 32'h0, 32'h4, 1, 32'h4);
      Stall = 1'b1;
      tick(); out("st1", 1, 32'h0, 32'h4, 0, 32'h8);
      tick(); out("st2", 1, 32'h0, 32'h4, 0, 32'h8);
      tick(); out("st3", 1, 32'h0, 32'h4, 0, 32'h8);
      Stall = 1'b0;
      tick(); out("st4", 1, 32'h4, 32'h8, 1, 32'h8);
      tick(); out("st5", 1, 32'h8, 32'hC, 1, 32'hC);
      do_reset();
      repeat (4) tick();
      check("rd.pre", IMemAddr, 32'h10);
      IMemReady = 1'b0; PCSrc = 1'b1; BranchTarget = 32'h40;
      tick(); out("rd1", 0, NOP, 32'h10, 1, 32'h10);
      PCSrc = 1'b0;
      tick(); out("rd2", 0, NOP, 32'h10, 1, 32'h10);
      IMemReady = 1'b1;
      tick(); out("rd3", 0, NOP, 32'h10, 1, 32'h40);
      tick(); out("rd4", 1, 32'h40, 32'h44, 1, 32'h44);
      do_reset();
      tick();
      Stall = 1'b1;
      tick(); out("pr0", 1, 32'h0, 32'h4, 0, 32'h8);
      Jump = 1'b1; JumpTarget = 32'h100; PCSrc = 1'b1; BranchTarget = 32'h80;
      tick(); out("pr1", 0, NOP, 32'h4, 1, 32'h100);
      Jump = 1'b0; PCSrc = 1'b0; Stall = 1'b0;
      tick(); out("pr2", 1, 32'h100, 32'h104, 1, 32'h104);
      do_reset();
      tick();
      IMemReady = 1'b0; Jump = 1'b1; JumpTarget = 32'h200;
      tick(); out("mr0", 0, NOP, 32'h4, 1, 32'h4);
      Jump = 1'b0; Rst = 1'b1; IMemReady = 1'b1;
      tick(); out("mr1", 0, NOP, 32'h0, 1, 32'h0);
      Rst = 1'b0;
      tick(); out("mr2", 1, 32'h0, 32'h4, 1, 32'h4);
      do_reset();
      Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
      tick(); out("wr1", 0, NOP, 32'h0, 1, 32'hFFFF_FFFC);
      Jump = 1'b0;
      tick(); out("wr2", 1, 32'hFFFF_FFFC, 32'h0, 1, 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
